// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - conditional branch resolution sequencer with operand wait and statistics
// Holds one branch until both operands arrive, then resolves it for one cycle.
module branch_resolve_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             br_valid_in,
  output logic             br_ready_out,
  input  logic [2:0]       br_funct3_in,
  input  logic [31:0]      br_pc_in,
  input  logic [31:0]      br_offset_in,
  input  logic             br_pred_taken_in,
  input  logic             rs1_ready_in,
  input  logic [31:0]      rs1_data_in,
  input  logic             rs2_ready_in,
  input  logic [31:0]      rs2_data_in,
  input  logic             flush_in,
  output logic             stall_out,
  output logic             resolved_valid_out,
  output logic             resolved_taken_out,
  output logic             redirect_valid_out,
  output logic [31:0]      redirect_pc_out,
  output logic [CNT_W-1:0] branch_count_out,
  output logic [CNT_W-1:0] mispredict_count_out
);

  typedef enum logic [1:0] {IDLE, WAIT_OPS, RESOLVE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_funct3;
  logic [31:0]      r_pc;
  logic [31:0]      r_offset;
  logic             r_pred;
  logic [31:0]      r_rs1;
  logic [31:0]      r_rs2;
  logic             r_have1;
  logic             r_have2;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mp_cnt;

  logic             w_accept;
  logic             w_cap1;
  logic             w_cap2;
  logic             w_taken;
  logic             w_mispredict;
  logic             w_retire;
  logic [31:0]      w_target;

  assign br_ready_out = (r_state == IDLE) & ~flush_in;
  assign stall_out    = (r_state == WAIT_OPS);
  assign w_accept     = br_valid_in & br_ready_out;

  // An operand is latched at most once per branch; later ready pulses are ignored.
  assign w_cap1 = rs1_ready_in & ~flush_in &
                  (w_accept | ((r_state == WAIT_OPS) & ~r_have1));
  assign w_cap2 = rs2_ready_in & ~flush_in &
                  (w_accept | ((r_state == WAIT_OPS) & ~r_have2));

  always_comb begin
    w_state_nxt = r_state;
    if (flush_in) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept)
            w_state_nxt = (rs1_ready_in & rs2_ready_in) ? RESOLVE : WAIT_OPS;
        end
        WAIT_OPS: begin
          if ((r_have1 | rs1_ready_in) & (r_have2 | rs2_ready_in))
            w_state_nxt = RESOLVE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_funct3)
      3'b000:  w_taken = (r_rs1 == r_rs2);
      3'b001:  w_taken = (r_rs1 != r_rs2);
      3'b100:  w_taken = (r_rs1 <  r_rs2);
      3'b101:  w_taken = (r_rs1 >= r_rs2);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_target     = r_pc + (w_taken ? r_offset : 32'd4);
  assign w_mispredict = w_taken ^ r_pred;
  assign w_retire     = (r_state == RESOLVE) & ~flush_in;

  assign resolved_valid_out   = w_retire;
  assign resolved_taken_out   = (r_state == RESOLVE) & w_taken;
  assign redirect_valid_out   = w_retire & w_mispredict;
  assign redirect_pc_out      = (r_state == RESOLVE) ? w_target : 32'd0;
  assign branch_count_out     = r_br_cnt;
  assign mispredict_count_out = r_mp_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_funct3 <= 3'd0;
      r_pc     <= 32'd0;
      r_offset <= 32'd0;
      r_pred   <= 1'b0;
      r_rs1    <= 32'd0;
      r_rs2    <= 32'd0;
      r_have1  <= 1'b0;
      r_have2  <= 1'b0;
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_funct3 <= br_funct3_in;
        r_pc     <= br_pc_in;
        r_offset <= br_offset_in;
        r_pred   <= br_pred_taken_in;
      end
      if (w_cap1)
        r_rs1 <= rs1_data_in;
      if (w_cap2)
        r_rs2 <= rs2_data_in;
      if (flush_in || (r_state == RESOLVE)) begin
        r_have1 <= 1'b0;
        r_have2 <= 1'b0;
      end else begin
        if (w_cap1)
          r_have1 <= 1'b1;
        if (w_cap2)
          r_have2 <= 1'b1;
      end
      if (w_retire) begin
        if (r_br_cnt != {CNT_W{1'b1}})
          r_br_cnt <= r_br_cnt + 1'b1;
        if (w_mispredict && (r_mp_cnt != {CNT_W{1'b1}}))
          r_mp_cnt <= r_mp_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed self-checking bench for branch_resolve_ctrl
// A narrow-counter second instance shares the stimulus so saturation is reachable quickly.
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        reset_n;
  logic        br_valid_in;
  logic        br_ready_out;
  logic [2:0]  br_funct3_in;
  logic [31:0] br_pc_in;
  logic [31:0] br_offset_in;
  logic        br_pred_taken_in;
  logic        rs1_ready_in;
  logic [31:0] rs1_data_in;
  logic        rs2_ready_in;
  logic [31:0] rs2_data_in;
  logic        flush_in;
  logic        stall_out;
  logic        resolved_valid_out;
  logic        resolved_taken_out;
  logic        redirect_valid_out;
  logic [31:0] redirect_pc_out;
  logic [15:0] branch_count_out;
  logic [15:0] mispredict_count_out;

  logic        s_ready, s_stall, s_rv, s_rt, s_xv;
  logic [31:0] s_pc;
  logic [3:0]  s_bc, s_mc;

  int n_cmp = 0;
  int n_err = 0;

  branch_resolve_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .br_valid_in(br_valid_in), .br_ready_out(br_ready_out),
    .br_funct3_in(br_funct3_in), .br_pc_in(br_pc_in), .br_offset_in(br_offset_in),
    .br_pred_taken_in(br_pred_taken_in),
    .rs1_ready_in(rs1_ready_in), .rs1_data_in(rs1_data_in),
    .rs2_ready_in(rs2_ready_in), .rs2_data_in(rs2_data_in),
    .flush_in(flush_in), .stall_out(stall_out),
    .resolved_valid_out(resolved_valid_out), .resolved_taken_out(resolved_taken_out),
    .redirect_valid_out(redirect_valid_out), .redirect_pc_out(redirect_pc_out),
    .branch_count_out(branch_count_out), .mispredict_count_out(mispredict_count_out)
  );

  branch_resolve_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .br_valid_in(br_valid_in), .br_ready_out(s_ready),
    .br_funct3_in(br_funct3_in), .br_pc_in(br_pc_in), .br_offset_in(br_offset_in),
    .br_pred_taken_in(br_pred_taken_in),
    .rs1_ready_in(rs1_ready_in), .rs1_data_in(rs1_data_in),
    .rs2_ready_in(rs2_ready_in), .rs2_data_in(rs2_data_in),
    .flush_in(flush_in), .stall_out(s_stall),
    .resolved_valid_out(s_rv), .resolved_taken_out(s_rt),
    .redirect_valid_out(s_xv), .redirect_pc_out(s_pc),
    .branch_count_out(s_bc), .mispredict_count_out(s_mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_valid_in = 1'b0; br_funct3_in = 3'd0; br_pc_in = 32'd0; br_offset_in = 32'd0;
    br_pred_taken_in = 1'b0; rs1_ready_in = 1'b0; rs1_data_in = 32'd0;
    rs2_ready_in = 1'b0; rs2_data_in = 32'd0; flush_in = 1'b0;
  endtask

  // Presents a branch for exactly one accepting edge, then drops the request.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] off, input logic pred,
                       input logic ra, input logic [31:0] a,
                       input logic rb, input logic [31:0] b);
    br_valid_in = 1'b1; br_funct3_in = f3; br_pc_in = pc; br_offset_in = off;
    br_pred_taken_in = pred; rs1_ready_in = ra; rs1_data_in = a;
    rs2_ready_in = rb; rs2_data_in = b;
    #1;
    chk({tag, "_ready"}, {31'd0, br_ready_out}, 32'd1);
    step();
    br_valid_in = 1'b0; rs1_ready_in = 1'b0; rs2_ready_in = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic rv, input logic rt,
                            input logic xv, input logic [31:0] pc);
    chk({tag, "_rvalid"}, {31'd0, resolved_valid_out}, {31'd0, rv});
    chk({tag, "_rtaken"}, {31'd0, resolved_taken_out}, {31'd0, rt});
    chk({tag, "_xvalid"}, {31'd0, redirect_valid_out}, {31'd0, xv});
    chk({tag, "_xpc"}, redirect_pc_out, pc);
  endtask

  task automatic expect_cnt(input string tag, input logic [15:0] bc, input logic [15:0] mc);
    chk({tag, "_bcnt"}, {16'd0, branch_count_out}, {16'd0, bc});
    chk({tag, "_mcnt"}, {16'd0, mispredict_count_out}, {16'd0, mc});
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    step(); step();
    chk("rst_ready", {31'd0, br_ready_out}, 32'd1);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    expect_res("rst", 1'b0, 1'b0, 1'b0, 32'd0);
    expect_cnt("rst", 16'd0, 16'd0);
    reset_n = 1'b1;
    step();

    // BEQ taken, predicted not-taken: mispredict to pc+offset
    issue("beq", 3'b000, 32'h100, 32'h20, 1'b0, 1'b1, 32'd5, 1'b1, 32'd5);
    chk("beq_busy", {31'd0, br_ready_out}, 32'd0);
    expect_res("beq", 1'b1, 1'b1, 1'b1, 32'h120);
    step();
    expect_res("beq_after", 1'b0, 1'b0, 1'b0, 32'd0);
    expect_cnt("beq", 16'd1, 16'd1);

    // Unsigned compare: 0xFFFFFFFF is not below 1
    issue("blt", 3'b100, 32'h200, 32'h40, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd1);
    expect_res("blt", 1'b1, 1'b0, 1'b0, 32'h204);
    step();
    issue("bge", 3'b101, 32'h300, 32'h10, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd1);
    expect_res("bge", 1'b1, 1'b1, 1'b1, 32'h310);
    step();
    expect_cnt("bge", 16'd3, 16'd2);

    // BNE waits for rs2; a later rs1 value must not replace the latched one
    issue("bne", 3'b001, 32'h400, 32'h40, 1'b1, 1'b1, 32'd7, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bne_stall", {31'd0, stall_out}, 32'd1);
      chk("bne_ready", {31'd0, br_ready_out}, 32'd0);
      chk("bne_norv", {31'd0, resolved_valid_out}, 32'd0);
      rs1_ready_in = 1'b1; rs1_data_in = 32'd9;
      if (i == 2) begin
        rs2_ready_in = 1'b1; rs2_data_in = 32'd7;
      end
      step();
    end
    rs1_ready_in = 1'b0; rs2_ready_in = 1'b0;
    chk("bne_res_stall", {31'd0, stall_out}, 32'd0);
    expect_res("bne", 1'b1, 1'b0, 1'b1, 32'h404);
    step();
    expect_cnt("bne", 16'd4, 16'd3);

    // PC arithmetic wraps modulo 2^32
    issue("wrap_t", 3'b000, 32'hFFFF_FFFC, 32'd8, 1'b1, 1'b1, 32'd1, 1'b1, 32'd1);
    expect_res("wrap_t", 1'b1, 1'b1, 1'b0, 32'h0000_0004);
    step();
    issue("wrap_n", 3'b001, 32'hFFFF_FFFC, 32'd8, 1'b0, 1'b1, 32'd1, 1'b1, 32'd1);
    expect_res("wrap_n", 1'b1, 1'b0, 1'b0, 32'h0000_0000);
    step();
    expect_cnt("wrap", 16'd6, 16'd3);

    // Flush in WAIT_OPS beats an arriving operand and drops the branch
    issue("fw", 3'b000, 32'h500, 32'h8, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0);
    chk("fw_stall", {31'd0, stall_out}, 32'd1);
    flush_in = 1'b1; rs2_ready_in = 1'b1; rs2_data_in = 32'd1;
    #1;
    chk("fw_ready_blocked", {31'd0, br_ready_out}, 32'd0);
    step();
    flush_in = 1'b0; rs2_ready_in = 1'b0;
    #1;
    chk("fw_idle_stall", {31'd0, stall_out}, 32'd0);
    chk("fw_idle_ready", {31'd0, br_ready_out}, 32'd1);
    expect_res("fw_idle", 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    expect_res("fw_quiet", 1'b0, 1'b0, 1'b0, 32'd0);
    expect_cnt("fw", 16'd6, 16'd3);

    // After flush the stale rs1 flag must be gone: rs2-only accept keeps waiting
    issue("pf", 3'b000, 32'h600, 32'h8, 1'b0, 1'b0, 32'd0, 1'b1, 32'd3);
    chk("pf_stall1", {31'd0, stall_out}, 32'd1);
    step();
    chk("pf_stall2", {31'd0, stall_out}, 32'd1);
    rs1_ready_in = 1'b1; rs1_data_in = 32'd3;
    step();
    rs1_ready_in = 1'b0;
    expect_res("pf", 1'b1, 1'b1, 1'b1, 32'h608);
    step();
    expect_cnt("pf", 16'd7, 16'd4);

    // Flush during RESOLVE suppresses the pulses and the count
    issue("fr", 3'b000, 32'h700, 32'h8, 1'b0, 1'b1, 32'd2, 1'b1, 32'd2);
    flush_in = 1'b1;
    #1;
    chk("fr_rvalid", {31'd0, resolved_valid_out}, 32'd0);
    chk("fr_xvalid", {31'd0, redirect_valid_out}, 32'd0);
    step();
    flush_in = 1'b0;
    expect_cnt("fr", 16'd7, 16'd4);
    issue("nx", 3'b000, 32'h800, 32'h4, 1'b1, 1'b1, 32'd2, 1'b1, 32'd3);
    expect_res("nx", 1'b1, 1'b0, 1'b1, 32'h804);
    step();
    expect_cnt("nx", 16'd8, 16'd5);

    // Saturation: narrow instance stops at 4'hF, wide one keeps counting
    reset_n = 1'b0;
    #1;
    expect_cnt("sat_rst", 16'd0, 16'd0);
    chk("sat_rst_n", {24'd0, s_bc, s_mc}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      issue("sat", 3'b000, 32'h900, 32'h10, 1'b0, 1'b1, 32'd4, 1'b1, 32'd4);
      step();
      if (i == 14)
        chk("sat_at15", {24'd0, s_bc, s_mc}, 32'h0000_00FF);
    end
    chk("sat_hold_bc", {28'd0, s_bc}, 32'hF);
    chk("sat_hold_mc", {28'd0, s_mc}, 32'hF);
    expect_cnt("sat_wide", 16'd17, 16'd17);

    // Asynchronous reset while waiting on an operand abandons the branch
    issue("ar", 3'b000, 32'hA00, 32'h10, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0);
    chk("ar_stall", {31'd0, stall_out}, 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_stall0", {31'd0, stall_out}, 32'd0);
    chk("ar_ready", {31'd0, br_ready_out}, 32'd1);
    expect_cnt("ar", 16'd0, 16'd0);
    rs2_ready_in = 1'b1; rs2_data_in = 32'd1;
    step();
    reset_n = 1'b1;
    step();
    rs2_ready_in = 1'b0;
    expect_res("ar_quiet", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("ar_idle", {31'd0, stall_out}, 32'd0);
    step();
    expect_res("ar_quiet2", 1'b0, 1'b0, 1'b0, 32'd0);
    expect_cnt("ar_end", 16'd0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution for the Elpis core.
- Accepts one conditional branch at a time from decode and waits until both source operands are available, for example behind a multi-cycle load.
- Performs the branch comparison, computes the resolved next PC, and raises a redirect when the resolved direction differs from the front-end prediction.
- Keeps saturating statistics counters for branches and mispredicts.

Parameters:
CNT_W, 16, width of the branch and mispredict statistics counters

Ports:
clk  in  1  core clock, all state updates on the rising edge
reset_n  in  1  asynchronous active-low reset
br_valid_in  in  1  decode presents a branch
br_ready_out  out  1  block can accept a branch this cycle
br_funct3_in  in  3  branch funct3 code
br_pc_in  in  32  PC of the branch
br_offset_in  in  32  sign-extended B-immediate
br_pred_taken_in  in  1  front-end predicted direction
rs1_ready_in  in  1  rs1_data_in is valid this cycle
rs1_data_in  in  32  rs1 value, forwarded live
rs2_ready_in  in  1  rs2_data_in is valid this cycle
rs2_data_in  in  32  rs2 value, forwarded live
flush_in  in  1  kill any in-flight branch (exception or older redirect)
stall_out  out  1  decode must hold: branch waiting on operands
resolved_valid_out  out  1  one-cycle pulse, branch resolved
resolved_taken_out  out  1  resolved direction, valid with resolved_valid_out
redirect_valid_out  out  1  one-cycle pulse on mispredict
redirect_pc_out  out  32  correct next PC, valid with resolved_valid_out
branch_count_out  out  CNT_W  branches resolved, saturating
mispredict_count_out  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - All capture registers and both counters clear to 0.
  - resolved_valid_out, resolved_taken_out, redirect_valid_out, redirect_pc_out and stall_out read 0.
  - br_ready_out reads 1, but no accept can occur while reset_n is low.
- States: IDLE, WAIT_OPS, RESOLVE.
- br_ready_out = (state==IDLE) & ~flush_in.
- stall_out = (state==WAIT_OPS).
- Accept occurs when br_valid_in & br_ready_out. On accept:
  - Capture funct3, pc, offset and pred_taken.
  - Capture rs1 if rs1_ready_in is high; capture rs2 if rs2_ready_in is high. Each captured operand sets a sticky "have" flag.
- Transitions:
  - IDLE with no accept: stay in IDLE.
  - IDLE with accept and both operands ready that cycle: go to RESOLVE; otherwise go to WAIT_OPS.
  - WAIT_OPS:
    - Each cycle, latch any operand whose ready bit is high and whose have flag is clear. A latched operand is never overwritten.
    - Go to RESOLVE on the edge where both have flags are set, counting operands latched that same cycle.
  - RESOLVE: lasts exactly one cycle, then IDLE. Have flags clear on leaving.
- Comparison, performed in RESOLVE on the latched operands:
  - 000 BEQ: a==b.
  - 001 BNE: a!=b.
  - 100 BLT: a<b.
  - 101 BGE: a>=b.
  - BLT and BGE are 32-bit unsigned magnitude comparisons, identical to the core's existing comparator.
  - Any other funct3 resolves not-taken.
- Outputs in RESOLVE (combinational from latched registers):
  - resolved_valid_out=1 and resolved_taken_out=taken.
  - redirect_pc_out = taken ? pc+offset : pc+4, computed modulo 2^32 (wrap-around discarded).
  - redirect_valid_out = taken ^ pred_taken.
  - Outside RESOLVE, all four outputs read 0.
- Latency: accept at edge N with both operands ready gives resolution in cycle N+1. Maximum throughput is one branch per 2 cycles.
- Counters: on the edge leaving RESOLVE (not flushed):
  - branch_count increments.
  - mispredict_count increments if redirect_valid_out was 1.
  - Both saturate at all-ones and never wrap.
- flush_in (highest priority, below reset):
  - From any state, the next edge returns to IDLE and clears the have flags.
  - In RESOLVE, flush_in forces resolved_valid_out and redirect_valid_out to 0 that cycle, and the counters do not change.
  - In IDLE, flush_in blocks the accept.
- Reset mid-operation: abandons any branch with no output pulse.
- Operand ready signals arriving while in IDLE without an accept, or while in RESOLVE, are ignored.

Test Plan:
- BEQ, pc=0x100, offset=0x20, pred=0, rs1=rs2=5, both ready at accept: RESOLVE next cycle with taken=1, redirect_valid=1, redirect_pc=0x120; branch_count=1, mispredict_count=1.
- BLT, a=0xFFFFFFFF, b=1, pred=0: not taken (unsigned), redirect_valid=0, redirect_pc=pc+4. BGE on the same operands: taken.
- BNE with rs1 ready at accept, rs2 ready 3 cycles later:
  - stall_out high for 3 cycles and br_ready_out low.
  - rs1 changing while have-flag set does not alter the result.
  - Resolves the cycle after rs2_ready.
- pc=0xFFFFFFFC, offset=8, BEQ taken: redirect_pc=0x00000004. pc=0xFFFFFFFC not taken: redirect_pc=0x00000000.
- flush_in during WAIT_OPS, and separately during RESOLVE: no resolved/redirect pulse, counters unchanged, next branch accepted normally.
- Preload or drive 0xFFFF mispredicts with CNT_W=16, then one more mispredict: both counters hold 0xFFFF. Async reset_n pulse mid-WAIT_OPS: counters=0, state IDLE, no pulses.
